// File: rtl/fft_ram_copy.sv
// Copies FFT_SIZE words from the FFT output buffer to the FFT input buffer over one Avalon-MM
// master port. Define FFT_RAM_COPY_SHIFT_EN to add a circular frequency-bin shift on the destination.
`ifndef BEL_FFT_DWIDTH
`define BEL_FFT_DWIDTH 32
`endif

module fft_ram_copy #(
    parameter int unsigned FFT_SIZE = 1024,
    parameter int unsigned DWIDTH   = `BEL_FFT_DWIDTH,
    parameter int unsigned AWIDTH   = $clog2(FFT_SIZE) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_start,
    input  logic [AWIDTH-2:0] i_shift,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ram_control,
    output logic [AWIDTH-1:0] o_ram_address,
    output logic              o_ram_read,
    output logic              o_ram_write,
    output logic [DWIDTH-1:0] o_ram_writedata,
    input  logic [DWIDTH-1:0] i_ram_readdata,
    input  logic              i_ram_waitrequest,
    input  logic              i_ram_readdatavalid
);

    localparam int unsigned KW = AWIDTH - 1;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StDone
    } state_e;

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   k_next;
    logic [KW-1:0]   dst_addr;

    assign k_next = k_q + KW'(1);

`ifdef FFT_RAM_COPY_SHIFT_EN
    logic [KW-1:0] shift_q;

    // KW-bit add: the carry out is the modulo-FFT_SIZE wrap.
    assign dst_addr = k_q + shift_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
        end else if (state_q == StIdle && i_start) begin
            shift_q <= i_shift;
        end
    end
`else
    logic unused_shift;

    assign unused_shift = ^i_shift;
    assign dst_addr     = k_q;
`endif

    assign o_ram_control = o_busy;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            k_q             <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_ram_address   <= '0;
            o_ram_read      <= 1'b0;
            o_ram_write     <= 1'b0;
            o_ram_writedata <= '0;
        end else begin
            o_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q       <= StRdReq;
                        k_q           <= '0;
                        o_busy        <= 1'b1;
                        o_ram_read    <= 1'b1;
                        o_ram_address <= {1'b1, {KW{1'b0}}};
                    end
                end
                StRdReq: begin
                    if (!i_ram_waitrequest) begin
                        o_ram_read <= 1'b0;
                        state_q    <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (i_ram_readdatavalid) begin
                        o_ram_writedata <= i_ram_readdata;
                        o_ram_write     <= 1'b1;
                        o_ram_address   <= {1'b0, dst_addr};
                        state_q         <= StWrReq;
                    end
                end
                StWrReq: begin
                    if (!i_ram_waitrequest) begin
                        o_ram_write <= 1'b0;
                        if (&k_q) begin
                            state_q <= StDone;
                            o_done  <= 1'b1;
                        end else begin
                            k_q           <= k_next;
                            o_ram_read    <= 1'b1;
                            o_ram_address <= {1'b1, k_next};
                            state_q       <= StRdReq;
                        end
                    end
                end
                StDone: begin
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_ram_copy.sv
// Scoreboarded bench for fft_ram_copy: a randomising Avalon slave model, a reference copy model
// that queues the expected write stream, and a monitor that checks each accepted write.
module tb_fft_ram_copy;

    localparam int N  = 1024;
    localparam int KW = 10;
    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [KW-1:0] i_shift;
    logic          o_busy, o_done, o_ram_control, o_ram_read, o_ram_write;
    logic [AW-1:0] o_ram_address;
    logic [DW-1:0] o_ram_writedata;
    logic [DW-1:0] i_ram_readdata;
    logic          i_ram_waitrequest;
    logic          i_ram_readdatavalid;

    always #5 clk = ~clk;

    fft_ram_copy dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .i_start            (i_start),
        .i_shift            (i_shift),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_ram_control      (o_ram_control),
        .o_ram_address      (o_ram_address),
        .o_ram_read         (o_ram_read),
        .o_ram_write        (o_ram_write),
        .o_ram_writedata    (o_ram_writedata),
        .i_ram_readdata     (i_ram_readdata),
        .i_ram_waitrequest  (i_ram_waitrequest),
        .i_ram_readdatavalid(i_ram_readdatavalid)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            start_cyc;
    int            done_cyc;
    int            done_cnt = 0;
    int            wr_cnt   = 0;
    bit            bp       = 0;
    logic [DW-1:0] mem_out [N];
    logic [DW-1:0] mem_in  [N];
    logic [DW-1:0] exp_in  [N];
    wr_t           exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int dest(input int k, input int s);
`ifdef FFT_RAM_COPY_SHIFT_EN
        return (k + s) % N;
`else
        return k + 0 * s;
`endif
    endfunction

    // Avalon slave: random waitrequest and 0-5 cycle read latency when bp is set.
    initial begin
        bit            rd_acc, wr_acc, pend;
        int            dly;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [KW-1:0] raddr;
        pend = 0;
        dly  = 0;
        raddr = '0;
        i_ram_waitrequest   = 1'b0;
        i_ram_readdatavalid = 1'b0;
        i_ram_readdata      = '0;
        forever begin
            @(negedge clk);
            rd_acc = o_ram_read && !i_ram_waitrequest && !rst;
            wr_acc = o_ram_write && !i_ram_waitrequest && !rst;
            a      = o_ram_address;
            d      = o_ram_writedata;
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 0;
                i_ram_readdatavalid = 1'b0;
                i_ram_waitrequest   = 1'b0;
            end else begin
                if (wr_acc) mem_in[a[KW-1:0]] = d;
                if (rd_acc) begin
                    pend  = 1;
                    dly   = bp ? int'($urandom_range(0, 5)) : 0;
                    raddr = a[KW-1:0];
                end
                if (pend && dly == 0) begin
                    i_ram_readdatavalid = 1'b1;
                    i_ram_readdata      = mem_out[raddr];
                    pend = 0;
                end else begin
                    i_ram_readdatavalid = 1'b0;
                    i_ram_readdata      = $urandom;
                    if (pend) dly--;
                end
                i_ram_waitrequest = bp ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Monitor: protocol invariants and scoreboard pops on every accepted write.
    initial begin
        bit          stall_prev;
        logic [44:0] prev_req;
        wr_t         w;
        stall_prev = 0;
        prev_req   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                check("rd_wr_exclusive", 64'(o_ram_read & o_ram_write), 64'd0);
                check("ram_control", 64'(o_ram_control), 64'(o_busy));
                if (stall_prev)
                    check("stalled_req_stable",
                          64'({o_ram_read, o_ram_write, o_ram_address, o_ram_writedata}),
                          64'(prev_req));
                if (o_ram_read && !i_ram_waitrequest)
                    check("rd_addr", 64'(o_ram_address), 64'({1'b1, KW'(wr_cnt)}));
                if (o_ram_write && !i_ram_waitrequest) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(o_ram_address), 64'h7ff_0000);
                    end else begin
                        w = exp_q.pop_front();
                        check("wr_addr", 64'(o_ram_address), 64'(w.addr));
                        check("wr_data", 64'(o_ram_writedata), 64'(w.data));
                    end
                    wr_cnt++;
                end
                if (o_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_write_count", 64'(wr_cnt), 64'(N));
                    check("busy_during_done", 64'(o_busy), 64'd1);
                end
                stall_prev = (o_ram_read || o_ram_write) && i_ram_waitrequest;
                prev_req   = {o_ram_read, o_ram_write, o_ram_address, o_ram_writedata};
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_done"}, 64'(o_done), 64'd0);
        check({tag, "_ctrl"}, 64'(o_ram_control), 64'd0);
        check({tag, "_rdwr"}, 64'({o_ram_read, o_ram_write}), 64'd0);
        check({tag, "_addr"}, 64'(o_ram_address), 64'd0);
        check({tag, "_wdata"}, 64'(o_ram_writedata), 64'd0);
    endtask

    task automatic fill_src(input bit ramp);
        for (int k = 0; k < N; k++) begin
            mem_out[k] = ramp ? DW'(k) : DW'($urandom);
            mem_in[k]  = 32'hdead_beef;
            exp_in[k]  = 32'hdead_beef;
        end
    endtask

    task automatic start_copy(input int s);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_shift = KW'(s);
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        i_shift   = KW'($urandom);
        start_cyc = cyc;
        wr_cnt    = 0;
        for (int k = 0; k < N; k++) begin
            wr_t w;
            int  dd;
            dd     = dest(k, s);
            w.addr = {1'b0, KW'(dd)};
            w.data = mem_out[k];
            exp_q.push_back(w);
            exp_in[dd] = mem_out[k];
        end
    endtask

    task automatic wait_done(input int limit);
        int  d0;
        bit  ok;
        d0 = done_cnt;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
        check("done_within_budget", 64'(ok), 64'd1);
    endtask

    task automatic wait_writes(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4 * N; i++) begin
            @(negedge clk);
            #1;
            if (wr_cnt >= n) begin
                ok = 1;
                break;
            end
        end
        check("reach_write_index", 64'(ok), 64'd1);
    endtask

    task automatic finish_copy(input string tag, input int d_before);
        int bad;
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done_once"}, 64'(done_cnt - d_before), 64'd1);
        check({tag, "_idle_after"}, 64'(o_busy), 64'd0);
        check({tag, "_done_low"}, 64'(o_done), 64'd0);
        check({tag, "_writes"}, 64'(wr_cnt), 64'(N));
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        bad = 0;
        for (int k = 0; k < N; k++) if (mem_in[k] !== exp_in[k]) bad++;
        check({tag, "_ram_contents"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int d0;
        int sh;
        rst     = 1'b0;
        i_start = 1'b0;
        i_shift = '0;
        #1 rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("idle");

        // Identity copy with ramp data and exact latency.
        bp = 0;
        fill_src(1'b1);
        d0 = done_cnt;
        start_copy(0);
        wait_done(4 * N);
        check("identity_latency", 64'(done_cyc - start_cyc + 1), 64'(3 * N + 1));
        finish_copy("identity", d0);
        check("identity_in0", 64'(mem_in[0]), 64'd0);
        check("identity_in1023", 64'(mem_in[1023]), 64'd1023);

        // Shift wrap test.
        fill_src(1'b1);
        d0 = done_cnt;
        start_copy(1000);
        wait_done(4 * N);
        check("shift_latency", 64'(done_cyc - start_cyc + 1), 64'(3 * N + 1));
        finish_copy("shift", d0);
`ifdef FFT_RAM_COPY_SHIFT_EN
        check("shift_in1000", 64'(mem_in[1000]), 64'd0);
        check("shift_in23", 64'(mem_in[23]), 64'd47);
        check("shift_in999", 64'(mem_in[999]), 64'd1023);
`else
        check("shift_in1000", 64'(mem_in[1000]), 64'd1000);
        check("shift_in23", 64'(mem_in[23]), 64'd23);
        check("shift_in999", 64'(mem_in[999]), 64'd999);
`endif

        // Backpressure with random data and random shift.
        bp = 1;
        fill_src(1'b0);
        sh = int'($urandom_range(0, N - 1));
        d0 = done_cnt;
        start_copy(sh);
        wait_done(12 * N);
        finish_copy("backpressure", d0);
        bp = 0;
        repeat (2) @(posedge clk);

        // Reset in the middle of a copy, then a clean restart.
        fill_src(1'b0);
        d0 = done_cnt;
        start_copy(37);
        wait_writes(500);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midreset_no_done", 64'(done_cnt - d0), 64'd0);
        check("midreset_idle", 64'(o_busy), 64'd0);
        fill_src(1'b0);
        d0 = done_cnt;
        start_copy(37);
        wait_done(4 * N);
        finish_copy("restart", d0);

        // i_start pulsed mid-copy must be ignored.
        fill_src(1'b0);
        d0 = done_cnt;
        start_copy(200);
        wait_writes(10);
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        wait_done(4 * N);
        repeat (40) @(posedge clk);
        finish_copy("start_busy", d0);

        // Shift of 5: identity unless the shift feature is built in.
        fill_src(1'b0);
        d0 = done_cnt;
        start_copy(5);
        wait_done(4 * N);
        finish_copy("shift5", d0);
`ifndef FFT_RAM_COPY_SHIFT_EN
        check("noshift_in5", 64'(mem_in[5]), 64'(mem_out[5]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
